// File: rtl/rs_issue_queue_if.sv
// Issue, CDB and ALU-dispatch bundle shared by the decode stage and the reservation station.
// The master side drives issue and CDB traffic; the slave side is the reservation station.
interface rs_issue_queue_if #(
    parameter int ROB_IDX_W = 4,
    parameter int OPT_W     = 6,
    parameter int WORD_W    = 32
);
    logic                 rs_full;
    logic                 rs_ena;
    logic [OPT_W-1:0]     rs_opt;
    logic [ROB_IDX_W-1:0] rs_src1;
    logic [ROB_IDX_W-1:0] rs_src2;
    logic [WORD_W-1:0]    rs_val1;
    logic [WORD_W-1:0]    rs_val2;
    logic [WORD_W-1:0]    rs_imm;
    logic [ROB_IDX_W-1:0] rs_rob_idx;

    logic                 cdb_alu_valid;
    logic [ROB_IDX_W-1:0] cdb_alu_src;
    logic [WORD_W-1:0]    cdb_alu_val;
    logic                 cdb_ld_valid;
    logic [ROB_IDX_W-1:0] cdb_ld_src;
    logic [WORD_W-1:0]    cdb_ld_val;

    logic                 alu_ena;
    logic [OPT_W-1:0]     alu_opt;
    logic [WORD_W-1:0]    alu_val1;
    logic [WORD_W-1:0]    alu_val2;
    logic [WORD_W-1:0]    alu_imm;
    logic [ROB_IDX_W-1:0] alu_rob_idx;

    modport master (
        input  rs_full, alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx,
        output rs_ena, rs_opt, rs_src1, rs_src2, rs_val1, rs_val2, rs_imm, rs_rob_idx,
        output cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_ld_valid, cdb_ld_src, cdb_ld_val
    );

    modport slave (
        output rs_full, alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx,
        input  rs_ena, rs_opt, rs_src1, rs_src2, rs_val1, rs_val2, rs_imm, rs_rob_idx,
        input  cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_ld_valid, cdb_ld_src, cdb_ld_val
    );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation station for the ALU path: holds issued ops until both operands arrive
// over the CDBs, then dispatches the lowest-index ready entry, one per cycle.
module rs_issue_queue #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 4,
    parameter int OPT_W     = 6,
    parameter int WORD_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic rb,
    rs_issue_queue_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]   valid_reg;
    logic [RS_SIZE-1:0]   valid_next;
    logic [OPT_W-1:0]     opt_reg  [RS_SIZE];
    logic [ROB_IDX_W-1:0] src1_reg [RS_SIZE];
    logic [ROB_IDX_W-1:0] src2_reg [RS_SIZE];
    logic [WORD_W-1:0]    val1_reg [RS_SIZE];
    logic [WORD_W-1:0]    val2_reg [RS_SIZE];
    logic [WORD_W-1:0]    imm_reg  [RS_SIZE];
    logic [ROB_IDX_W-1:0] rob_reg  [RS_SIZE];

    logic [RS_SIZE-1:0]   ready;
    logic [RS_SIZE-1:0]   free_slot;
    logic [IDX_W-1:0]     disp_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [CNT_W-1:0]     free_cnt;
    logic                 disp_fire;
    logic                 wr_fire;

    logic [ROB_IDX_W-1:0] new_src1;
    logic [ROB_IDX_W-1:0] new_src2;
    logic [WORD_W-1:0]    new_val1;
    logic [WORD_W-1:0]    new_val2;

    logic                 alu_ena_reg;
    logic [OPT_W-1:0]     alu_opt_reg;
    logic [WORD_W-1:0]    alu_val1_reg;
    logic [WORD_W-1:0]    alu_val2_reg;
    logic [WORD_W-1:0]    alu_imm_reg;
    logic [ROB_IDX_W-1:0] alu_rob_reg;

    // Tag 0 means "no producer", so it must never be treated as a CDB hit.
    function automatic logic tag_hit(input logic [ROB_IDX_W-1:0] tag,
                                     input logic                 cdb_valid,
                                     input logic [ROB_IDX_W-1:0] cdb_tag);
        return cdb_valid && (tag != '0) && (tag == cdb_tag);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
            assign ready[gi]     = valid_reg[gi] && (src1_reg[gi] == '0) && (src2_reg[gi] == '0);
            assign free_slot[gi] = !valid_reg[gi];
        end
    endgenerate

    always_comb begin
        disp_idx = '0;
        wr_idx   = '0;
        free_cnt = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i])     disp_idx = IDX_W'(i);
            if (free_slot[i]) wr_idx   = IDX_W'(i);
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            free_cnt = free_cnt + CNT_W'(free_slot[i]);
        end
    end

    // A slot being dispatched is still valid pre-edge, so it is never picked as the write target.
    assign disp_fire   = rdy && !rb && (|ready);
    assign wr_fire     = bus.rs_ena && !rb && (|free_slot);
    assign bus.rs_full = (free_cnt < CNT_W'(2));

    always_comb begin
        new_src1 = bus.rs_src1;
        new_val1 = bus.rs_val1;
        new_src2 = bus.rs_src2;
        new_val2 = bus.rs_val2;
        if (tag_hit(bus.rs_src1, bus.cdb_alu_valid, bus.cdb_alu_src)) begin
            new_src1 = '0;
            new_val1 = bus.cdb_alu_val;
        end else if (tag_hit(bus.rs_src1, bus.cdb_ld_valid, bus.cdb_ld_src)) begin
            new_src1 = '0;
            new_val1 = bus.cdb_ld_val;
        end
        if (tag_hit(bus.rs_src2, bus.cdb_alu_valid, bus.cdb_alu_src)) begin
            new_src2 = '0;
            new_val2 = bus.cdb_alu_val;
        end else if (tag_hit(bus.rs_src2, bus.cdb_ld_valid, bus.cdb_ld_src)) begin
            new_src2 = '0;
            new_val2 = bus.cdb_ld_val;
        end
    end

    always_comb begin
        valid_next = valid_reg;
        if (rb) begin
            valid_next = '0;
        end else begin
            if (disp_fire) valid_next[disp_idx] = 1'b0;
            if (wr_fire)   valid_next[wr_idx]   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_reg <= '0;
        else      valid_reg <= valid_next;
    end

    // Payload needs no reset: nothing reads it while the matching valid bit is clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_SIZE; i++) begin
            if (wr_fire && (wr_idx == IDX_W'(i))) begin
                opt_reg[i]  <= bus.rs_opt;
                src1_reg[i] <= new_src1;
                src2_reg[i] <= new_src2;
                val1_reg[i] <= new_val1;
                val2_reg[i] <= new_val2;
                imm_reg[i]  <= bus.rs_imm;
                rob_reg[i]  <= bus.rs_rob_idx;
            end else if (valid_reg[i]) begin
                if (tag_hit(src1_reg[i], bus.cdb_alu_valid, bus.cdb_alu_src)) begin
                    src1_reg[i] <= '0;
                    val1_reg[i] <= bus.cdb_alu_val;
                end else if (tag_hit(src1_reg[i], bus.cdb_ld_valid, bus.cdb_ld_src)) begin
                    src1_reg[i] <= '0;
                    val1_reg[i] <= bus.cdb_ld_val;
                end
                if (tag_hit(src2_reg[i], bus.cdb_alu_valid, bus.cdb_alu_src)) begin
                    src2_reg[i] <= '0;
                    val2_reg[i] <= bus.cdb_alu_val;
                end else if (tag_hit(src2_reg[i], bus.cdb_ld_valid, bus.cdb_ld_src)) begin
                    src2_reg[i] <= '0;
                    val2_reg[i] <= bus.cdb_ld_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_ena_reg  <= 1'b0;
            alu_opt_reg  <= '0;
            alu_val1_reg <= '0;
            alu_val2_reg <= '0;
            alu_imm_reg  <= '0;
            alu_rob_reg  <= '0;
        end else begin
            alu_ena_reg <= disp_fire;
            if (disp_fire) begin
                alu_opt_reg  <= opt_reg[disp_idx];
                alu_val1_reg <= val1_reg[disp_idx];
                alu_val2_reg <= val2_reg[disp_idx];
                alu_imm_reg  <= imm_reg[disp_idx];
                alu_rob_reg  <= rob_reg[disp_idx];
            end
        end
    end

    assign bus.alu_ena     = alu_ena_reg;
    assign bus.alu_opt     = alu_opt_reg;
    assign bus.alu_val1    = alu_val1_reg;
    assign bus.alu_val2    = alu_val2_reg;
    assign bus.alu_imm     = alu_imm_reg;
    assign bus.alu_rob_idx = alu_rob_reg;

    // Issuing into a full station is a decode-stage bug; the op is dropped by wr_fire.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(bus.rs_ena && !rb && !(|free_slot)));

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: issue, forwarding, wake-up, priority, back-pressure,
// rollback and asynchronous reset, with hand-computed expectations.
module tb_rs_issue_queue;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rb;
    int   tests = 0;
    int   fails = 0;

    rs_issue_queue_if #(.ROB_IDX_W(4), .OPT_W(6), .WORD_W(32)) bus ();

    rs_issue_queue #(.RS_SIZE(16), .ROB_IDX_W(4), .OPT_W(6), .WORD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rb  (rb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] opt, input logic [3:0] s1, input logic [31:0] v1,
                         input logic [3:0] s2, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [3:0] rob);
        bus.rs_ena     = 1'b1;
        bus.rs_opt     = opt;
        bus.rs_src1    = s1;
        bus.rs_val1    = v1;
        bus.rs_src2    = s2;
        bus.rs_val2    = v2;
        bus.rs_imm     = imm;
        bus.rs_rob_idx = rob;
    endtask

    task automatic cdb(input logic av, input logic [3:0] as, input logic [31:0] aval,
                       input logic lv, input logic [3:0] ls, input logic [31:0] lval);
        bus.cdb_alu_valid = av;
        bus.cdb_alu_src   = as;
        bus.cdb_alu_val   = aval;
        bus.cdb_ld_valid  = lv;
        bus.cdb_ld_src    = ls;
        bus.cdb_ld_val    = lval;
    endtask

    task automatic flush();
        rb = 1'b1;
        tick();
        rb = 1'b0;
    endtask

    task automatic test_reset();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL reset_alu_ena: got %0h want 0", bus.alu_ena); end
        tests++; if (bus.alu_val1 !== 32'h0) begin fails++; $display("FAIL reset_alu_val1: got %0h want 0", bus.alu_val1); end
        tests++; if (bus.alu_rob_idx !== 4'h0) begin fails++; $display("FAIL reset_alu_rob: got %0h want 0", bus.alu_rob_idx); end
        tests++; if (bus.rs_full !== 1'b0) begin fails++; $display("FAIL reset_rs_full: got %0h want 0", bus.rs_full); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        issue(6'd1, 4'd0, 32'd5, 4'd0, 32'd7, 32'd9, 4'd3);
        tick();
        bus.rs_ena = 1'b0;
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL basic_no_early: got %0h want 0", bus.alu_ena); end
        tick();
        tests++; if (bus.alu_ena !== 1'b1) begin fails++; $display("FAIL basic_ena: got %0h want 1", bus.alu_ena); end
        tests++; if (bus.alu_val1 !== 32'd5) begin fails++; $display("FAIL basic_val1: got %0h want 5", bus.alu_val1); end
        tests++; if (bus.alu_val2 !== 32'd7) begin fails++; $display("FAIL basic_val2: got %0h want 7", bus.alu_val2); end
        tests++; if (bus.alu_rob_idx !== 4'd3) begin fails++; $display("FAIL basic_rob: got %0h want 3", bus.alu_rob_idx); end
        tests++; if (bus.alu_opt !== 6'd1 || bus.alu_imm !== 32'd9) begin fails++; $display("FAIL basic_opt_imm: got %0h/%0h want 1/9", bus.alu_opt, bus.alu_imm); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0 || bus.alu_val1 !== 32'd5) begin fails++; $display("FAIL basic_hold: got ena %0h val1 %0h want 0/5", bus.alu_ena, bus.alu_val1); end
    endtask

    task automatic test_wakeup();
        issue(6'd2, 4'd4, 32'd0, 4'd0, 32'd1, 32'd0, 4'd5);
        tick();
        bus.rs_ena = 1'b0;
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL wake_pending: got %0h want 0", bus.alu_ena); end
        cdb(1'b1, 4'd4, 32'h55, 1'b0, 4'd0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL wake_same_cycle: got %0h want 0", bus.alu_ena); end
        tick();
        tests++; if (bus.alu_ena !== 1'b1) begin fails++; $display("FAIL wake_ena: got %0h want 1", bus.alu_ena); end
        tests++; if (bus.alu_val1 !== 32'h55) begin fails++; $display("FAIL wake_val1: got %0h want 55", bus.alu_val1); end
        tests++; if (bus.alu_rob_idx !== 4'd5 || bus.alu_val2 !== 32'd1) begin fails++; $display("FAIL wake_rob_val2: got %0h/%0h want 5/1", bus.alu_rob_idx, bus.alu_val2); end
        tick();
    endtask

    task automatic test_forward();
        issue(6'd3, 4'd0, 32'd11, 4'd6, 32'd0, 32'd0, 4'd6);
        cdb(1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h1234);
        tick();
        bus.rs_ena = 1'b0;
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        tests++; if (bus.alu_ena !== 1'b1) begin fails++; $display("FAIL fwd_ena: got %0h want 1", bus.alu_ena); end
        tests++; if (bus.alu_val2 !== 32'h1234) begin fails++; $display("FAIL fwd_val2: got %0h want 1234", bus.alu_val2); end
        tests++; if (bus.alu_val1 !== 32'd11 || bus.alu_rob_idx !== 4'd6) begin fails++; $display("FAIL fwd_val1_rob: got %0h/%0h want b/6", bus.alu_val1, bus.alu_rob_idx); end
        // Both CDBs carry the same tag: the ALU value must be captured.
        issue(6'd4, 4'd7, 32'd0, 4'd0, 32'd2, 32'd0, 4'd7);
        cdb(1'b1, 4'd7, 32'hAA, 1'b1, 4'd7, 32'hBB);
        tick();
        bus.rs_ena = 1'b0;
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_val1 !== 32'hAA) begin fails++; $display("FAIL fwd_alu_priority: got ena %0h val1 %0h want 1/aa", bus.alu_ena, bus.alu_val1); end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 15; i++) begin
            issue(6'd5, 4'(i + 1), 32'd0, 4'd0, 32'd0, 32'd0, 4'(i));
            tick();
            if (i == 13) begin
                tests++; if (bus.rs_full !== 1'b0) begin fails++; $display("FAIL full_at_14: got %0h want 0", bus.rs_full); end
            end
        end
        bus.rs_ena = 1'b0;
        tests++; if (bus.rs_full !== 1'b1) begin fails++; $display("FAIL full_at_15: got %0h want 1", bus.rs_full); end
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL full_no_dispatch: got %0h want 0", bus.alu_ena); end
        cdb(1'b1, 4'd3, 32'h77, 1'b0, 4'd0, 32'd0);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tests++; if (bus.rs_full !== 1'b1) begin fails++; $display("FAIL full_after_wake: got %0h want 1", bus.rs_full); end
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_rob_idx !== 4'd2 || bus.alu_val1 !== 32'h77) begin fails++; $display("FAIL full_dispatch: got ena %0h rob %0h val1 %0h want 1/2/77", bus.alu_ena, bus.alu_rob_idx, bus.alu_val1); end
        tests++; if (bus.rs_full !== 1'b0) begin fails++; $display("FAIL full_release: got %0h want 0", bus.rs_full); end
        flush();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 6; i++) begin
            issue(6'd8, 4'(i + 1), 32'd0, 4'd0, 32'd0, 32'd0, 4'(i + 8));
            tick();
        end
        bus.rs_ena = 1'b0;
        cdb(1'b1, 4'd3, 32'h30, 1'b1, 4'd6, 32'h60);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_rob_idx !== 4'd10 || bus.alu_val1 !== 32'h30) begin fails++; $display("FAIL prio_first: got ena %0h rob %0h val1 %0h want 1/a/30", bus.alu_ena, bus.alu_rob_idx, bus.alu_val1); end
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_rob_idx !== 4'd13 || bus.alu_val1 !== 32'h60) begin fails++; $display("FAIL prio_second: got ena %0h rob %0h val1 %0h want 1/d/60", bus.alu_ena, bus.alu_rob_idx, bus.alu_val1); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL prio_drained: got %0h want 0", bus.alu_ena); end
        flush();
        for (int i = 0; i < 3; i++) begin
            issue(6'd8, 4'(i + 1), 32'd0, 4'd0, 32'd0, 32'd0, 4'(i + 8));
            tick();
        end
        bus.rs_ena = 1'b0;
        rdy = 1'b0;
        cdb(1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
            tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL stall_cycle%0d: got %0h want 0", c, bus.alu_ena); end
        end
        rdy = 1'b1;
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_rob_idx !== 4'd10 || bus.alu_val1 !== 32'h33) begin fails++; $display("FAIL stall_resume: got ena %0h rob %0h val1 %0h want 1/a/33", bus.alu_ena, bus.alu_rob_idx, bus.alu_val1); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL stall_drained: got %0h want 0", bus.alu_ena); end
        flush();
    endtask

    task automatic test_back_to_back();
        issue(6'd6, 4'd0, 32'd1, 4'd0, 32'd2, 32'd0, 4'd1);
        tick();
        issue(6'd6, 4'd0, 32'd3, 4'd0, 32'd4, 32'd0, 4'd2);
        tick();
        bus.rs_ena = 1'b0;
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_rob_idx !== 4'd1 || bus.alu_val1 !== 32'd1) begin fails++; $display("FAIL b2b_first: got ena %0h rob %0h val1 %0h want 1/1/1", bus.alu_ena, bus.alu_rob_idx, bus.alu_val1); end
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_rob_idx !== 4'd2 || bus.alu_val1 !== 32'd3) begin fails++; $display("FAIL b2b_second: got ena %0h rob %0h val1 %0h want 1/2/3", bus.alu_ena, bus.alu_rob_idx, bus.alu_val1); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %0h want 0", bus.alu_ena); end
    endtask

    task automatic test_rollback();
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            issue(6'd9, (i == 0) ? 4'd0 : 4'(i), 32'd0, 4'd0, 32'd0, 32'd0, 4'(i));
            tick();
        end
        rdy = 1'b1;
        rb  = 1'b1;
        issue(6'd7, 4'd0, 32'h99, 4'd0, 32'h98, 32'd0, 4'd15);
        tick();
        rb = 1'b0;
        bus.rs_ena = 1'b0;
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL rb_no_dispatch: got %0h want 0", bus.alu_ena); end
        tests++; if (bus.rs_full !== 1'b0) begin fails++; $display("FAIL rb_not_full: got %0h want 0", bus.rs_full); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL rb_op_dropped: got %0h want 0", bus.alu_ena); end
        cdb(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2);
        tick();
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL rb_entries_gone: got %0h want 0", bus.alu_ena); end
    endtask

    task automatic test_mid_reset();
        issue(6'd10, 4'd0, 32'h42, 4'd0, 32'h43, 32'd0, 4'd9);
        tick();
        bus.rs_ena = 1'b0;
        tick();
        tests++; if (bus.alu_ena !== 1'b1 || bus.alu_val1 !== 32'h42) begin fails++; $display("FAIL mrst_pre: got ena %0h val1 %0h want 1/42", bus.alu_ena, bus.alu_val1); end
        rdy = 1'b0;
        issue(6'd10, 4'd0, 32'h50, 4'd0, 32'h51, 32'd0, 4'd4);
        tick();
        issue(6'd10, 4'd0, 32'h60, 4'd0, 32'h61, 32'd0, 4'd5);
        #2;
        rst = 1'b0;
        #1;
        tests++; if (bus.alu_val1 !== 32'h0 || bus.alu_rob_idx !== 4'h0) begin fails++; $display("FAIL mrst_async_clear: got val1 %0h rob %0h want 0/0", bus.alu_val1, bus.alu_rob_idx); end
        rdy = 1'b1;
        tick();
        rst = 1'b1;
        bus.rs_ena = 1'b0;
        tests++; if (bus.rs_full !== 1'b0 || bus.alu_ena !== 1'b0) begin fails++; $display("FAIL mrst_held: got full %0h ena %0h want 0/0", bus.rs_full, bus.alu_ena); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL mrst_flushed: got %0h want 0", bus.alu_ena); end
        tick();
        tests++; if (bus.alu_ena !== 1'b0) begin fails++; $display("FAIL mrst_inflight_ignored: got %0h want 0", bus.alu_ena); end
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        rb  = 1'b0;
        bus.rs_ena = 1'b0;
        issue(6'd0, 4'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0);
        bus.rs_ena = 1'b0;
        cdb(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        tick();
        tick();
        test_reset();
        test_basic();
        test_wakeup();
        test_forward();
        test_full();
        test_priority();
        test_back_to_back();
        test_rollback();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
